data_mem_access_ctrl: RTL and testbench
=======================================

DATA_MEM_ACCESS_CTRL -- requirements
Module: data_mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, width of every memory address and pointer.
REQ-002 Parameter DATA_W, default 16, width of every memory data word; ADDR_W SHALL equal DATA_W.
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, memory-stage request present.
REQ-006 Port req_ready, output, 1, block can accept a request.
REQ-007 Port req_op, input, 2, operation code: 00 LD, 01 ST, 10 LDI, 11 STI.
REQ-008 Port req_addr, input, ADDR_W, effective address from execute.
REQ-009 Port req_wdata, input, DATA_W, store data (ST/STI).
REQ-010 Port dmem_en, output, 1, data-memory access strobe.
REQ-011 Port dmem_we, output, 1, data-memory write enable; only valid with dmem_en.
REQ-012 Port dmem_addr, output, ADDR_W, data-memory address.
REQ-013 Port dmem_din, output, DATA_W, data-memory write data.
REQ-014 Port dmem_dout, input, DATA_W, data-memory read data; valid exactly one cycle after a read strobe.
REQ-015 Port rsp_valid, output, 1, one-cycle completion pulse.
REQ-016 Port rsp_data, output, DATA_W, loaded word (LD/LDI) or stored word (ST/STI).

Function
REQ-017 Request accepted on rising edge where req_valid=1 and req_ready=1; req_op, req_addr, req_wdata captured into op_q, addr_q, wdata_q.
REQ-018 req_ready SHALL be 1 only in IDLE; req_valid while not ready is ignored; inputs need not hold after acceptance.
REQ-019 FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP; all outputs decoded from registered state/fields only (no input-to-output combinational path).
REQ-020 IDLE -> ISSUE1 on acceptance, else stay.
REQ-021 ISSUE1: dmem_en=1, dmem_addr=addr_q, dmem_we=1 only for ST, dmem_din=wdata_q; next RESP for ST, else WAIT1.
REQ-022 WAIT1: capture dmem_dout into data_q; next RESP for LD, ISSUE2 for LDI/STI.
REQ-023 ISSUE2: dmem_en=1, dmem_addr=data_q (pointer), dmem_we=1 only for STI, dmem_din=wdata_q; next RESP for STI, WAIT2 for LDI.
REQ-024 WAIT2: capture dmem_dout into data_q; next RESP.
REQ-025 RESP: rsp_valid=1, rsp_data=data_q for LD/LDI, wdata_q for ST/STI; next IDLE.
REQ-026 Outside ISSUE1/ISSUE2, dmem_en=0 and dmem_we=0; dmem_addr/dmem_din hold last driven value.
REQ-027 rsp_data SHALL hold its value until the next RESP.
REQ-028 Latency acceptance-edge to rsp_valid: ST 2, LD 3, STI 4, LDI 5 cycles; next acceptance no earlier than cycle after RESP.
REQ-029 Pointer used verbatim, full 16-bit range; pointer 0x0000 or 0xFFFF SHALL not be special-cased; no address arithmetic.
REQ-030 Exactly one memory strobe for LD/ST, exactly two for LDI/STI, never a write before pointer capture.

Reset
REQ-031 reset_n=0 SHALL immediately (asynchronously) force state IDLE, req_ready=1 after release, dmem_en=0, dmem_we=0, rsp_valid=0, dmem_addr=0, dmem_din=0, rsp_data=0, op_q/addr_q/wdata_q/data_q=0.
REQ-032 Reset asserted mid-operation SHALL abort it with no further strobe and no rsp_valid; first cycle after release is IDLE.

Verification
REQ-033 LD addr 0x3000, mem[0x3000]=0xBEEF -> one read strobe at 0x3000, rsp_valid at +3, rsp_data=0xBEEF.
REQ-034 ST addr 0x4010 data 0x1234 -> one strobe dmem_we=1 addr 0x4010 din 0x1234 at +1, rsp_valid at +2, rsp_data=0x1234.
REQ-035 LDI addr 0x3002, mem[0x3002]=0x5000, mem[0x5000]=0x00A5 -> reads at 0x3002 then 0x5000, rsp_valid at +5, rsp_data=0x00A5.
REQ-036 STI addr 0x3003, mem[0x3003]=0xFFFF, data 0x7777 -> read 0x3003, write 0xFFFF=0x7777 at +3, rsp_valid at +4.
REQ-037 req_valid held high with 3 back-to-back LDs -> req_ready low during each, 4-cycle spacing between acceptances, three rsp_valid pulses in order.
REQ-038 reset_n pulsed low during WAIT1 of LDI -> dmem_en=0 immediately, no second strobe, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/data_mem_access_ctrl_if.sv
// Memory-stage request/response and data-memory bus bundle.
// The slave modport is the controller's view; master is the view of the
// pipeline and memory that surround it.
interface data_mem_access_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              dmem_en;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_din;
   logic [DATA_W-1:0] dmem_dout;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, dmem_dout,
      output req_ready, dmem_en, dmem_we, dmem_addr, dmem_din, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, dmem_dout,
      input  req_ready, dmem_en, dmem_we, dmem_addr, dmem_din, rsp_valid, rsp_data
   );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Memory-stage access controller: LD/ST take one data-memory access,
// LDI/STI first read a pointer and then access the location it names.
// Every output is decoded from registered state and captured fields only.
module data_mem_access_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   data_mem_access_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP} state_t;

   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_ST  = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_STI = 2'b11;

   state_t            state, next_state;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] data_q;
   // Last driven bus/response values, held while the controller is not driving.
   logic [ADDR_W-1:0] addr_hold_q;
   logic [DATA_W-1:0] din_hold_q;
   logic [DATA_W-1:0] rsp_hold_q;

   logic              req_ready;
   logic              dmem_en;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_din;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              accept;

   assign accept = bus.req_valid && req_ready;

   // State register; reset aborts any access in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next state and all bus/response outputs from the current state.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      dmem_en    = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = addr_hold_q;
      dmem_din   = din_hold_q;
      rsp_valid  = 1'b0;
      rsp_data   = rsp_hold_q;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) next_state = ISSUE1;
         end
         ISSUE1: begin
            dmem_en    = 1'b1;
            dmem_we    = (op_q == OP_ST);
            dmem_addr  = addr_q;
            dmem_din   = wdata_q;
            next_state = (op_q == OP_ST) ? RESP : WAIT1;
         end
         WAIT1: next_state = (op_q == OP_LD) ? RESP : ISSUE2;
         ISSUE2: begin
            // Pointer from the first read is used verbatim as the address.
            dmem_en    = 1'b1;
            dmem_we    = (op_q == OP_STI);
            dmem_addr  = data_q;
            dmem_din   = wdata_q;
            next_state = (op_q == OP_STI) ? RESP : WAIT2;
         end
         WAIT2: next_state = RESP;
         RESP: begin
            rsp_valid  = 1'b1;
            // Stores report the word written; loads report the word read.
            rsp_data   = (op_q == OP_ST || op_q == OP_STI) ? wdata_q : data_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request capture, read-data capture and output hold registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q        <= OP_LD;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
         rsp_hold_q  <= '0;
      end else begin
         if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == WAIT1 || state == WAIT2) data_q <= bus.dmem_dout;
         if (dmem_en) begin
            addr_hold_q <= dmem_addr;
            din_hold_q  <= dmem_din;
         end
         if (rsp_valid) rsp_hold_q <= rsp_data;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.dmem_en   = dmem_en;
   assign bus.dmem_we   = dmem_we;
   assign bus.dmem_addr = dmem_addr;
   assign bus.dmem_din  = dmem_din;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Scoreboard bench for data_mem_access_ctrl: stimulus pushes expected
// strobes and responses; negedge monitors pop and compare them.
module tb_data_mem_access_ctrl;
   typedef struct {
      int          cyc;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t strb_q[$];
   exp_t rsp_q[$];
   logic [15:0] mem [0:65535];
   logic [15:0] last_rsp = 16'h0000;

   data_mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   data_mem_access_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous memory: read data appears the cycle after the strobe.
   always @(posedge clock) begin
      if (bus.dmem_en) begin
         if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_din;
         bus.dmem_dout <= mem[bus.dmem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Strobe monitor.
   always @(negedge clock) begin
      if (bus.dmem_en === 1'b1) begin
         if (strb_q.size() == 0) check("unexpected_strobe", {16'h0, bus.dmem_addr}, 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = strb_q.pop_front();
            check("strobe_cycle", cyc + 1, e.cyc);
            check("strobe_we", {31'h0, bus.dmem_we}, {31'h0, e.we});
            check("strobe_addr", {16'h0, bus.dmem_addr}, {16'h0, e.addr});
            if (e.we) check("strobe_din", {16'h0, bus.dmem_din}, {16'h0, e.data});
         end
      end
   end

   // Response monitor.
   always @(negedge clock) begin
      if (bus.rsp_valid === 1'b1) begin
         if (rsp_q.size() == 0) check("unexpected_rsp", {16'h0, bus.rsp_data}, 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = rsp_q.pop_front();
            check("rsp_cycle", cyc + 1, e.cyc);
            check("rsp_data", {16'h0, bus.rsp_data}, {16'h0, e.data});
            last_rsp = e.data;
         end
      end
   end

   // Present one request (called at a negedge), wait for acceptance and push
   // the hand-derived strobe/response timeline. Leaves req_valid high.
   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] ptr, input logic [15:0] rsp, input bit abort,
                        output int acc);
      int n;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      acc = -1;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         check("ready_timeout", 32'h0, 32'h1);
         return;
      end
      acc = cyc + 1;
      e.cyc = acc + 1; e.we = (op == 2'b01); e.addr = addr; e.data = wdata;
      strb_q.push_back(e);
      if (!abort) begin
         if (op[1]) begin
            e.cyc = acc + 3; e.we = (op == 2'b11); e.addr = ptr; e.data = wdata;
            strb_q.push_back(e);
         end
         case (op)
            2'b00:   e.cyc = acc + 3;
            2'b01:   e.cyc = acc + 2;
            2'b10:   e.cyc = acc + 5;
            default: e.cyc = acc + 4;
         endcase
         e.we = 1'b0; e.addr = 16'h0; e.data = rsp;
         rsp_q.push_back(e);
      end
      @(negedge clock);
   endtask

   // Drop req_valid and wait (bounded) for the scoreboard to empty.
   task automatic drain();
      int n;
      bus.req_valid = 1'b0;
      n = 0;
      while ((strb_q.size() != 0 || rsp_q.size() != 0 || bus.req_ready !== 1'b1) && n < 30) begin
         @(negedge clock);
         n++;
      end
      check("drain_empty", {16'h0, 8'(strb_q.size()), 8'(rsp_q.size())}, 32'h0);
      repeat (2) @(negedge clock);
      check("rsp_data_hold", {16'h0, bus.rsp_data}, {16'h0, last_rsp});
   endtask

   initial begin
      int a0, a1, a2;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_addr  = 16'h0;
      bus.req_wdata = 16'h0;
      bus.dmem_dout = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
      mem[16'h3000] = 16'hBEEF;
      mem[16'h3001] = 16'hCAFE;
      mem[16'h3002] = 16'h5000;
      mem[16'h5000] = 16'h00A5;
      mem[16'h3003] = 16'hFFFF;
      mem[16'h3004] = 16'h0000;
      mem[16'h0000] = 16'h1111;

      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_en_we_vld", {29'h0, bus.dmem_en, bus.dmem_we, bus.rsp_valid}, 32'h0);
      check("rst_addr_din", {bus.dmem_addr, bus.dmem_din}, 32'h0);
      check("rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);

      // op, addr, wdata, pointer, expected rsp_data
      issue(2'b00, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, a0); drain();
      issue(2'b01, 16'h4010, 16'h1234, 16'h0000, 16'h1234, 1'b0, a0); drain();
      check("mem_st", {16'h0, mem[16'h4010]}, 32'h1234);
      issue(2'b10, 16'h3002, 16'h0000, 16'h5000, 16'h00A5, 1'b0, a0); drain();
      issue(2'b11, 16'h3003, 16'h7777, 16'hFFFF, 16'h7777, 1'b0, a0); drain();
      check("mem_sti", {16'h0, mem[16'hFFFF]}, 32'h7777);
      issue(2'b10, 16'h3004, 16'h0000, 16'h0000, 16'h1111, 1'b0, a0); drain();
      issue(2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h7777, 1'b0, a0); drain();

      // Back-to-back loads with req_valid held high.
      issue(2'b00, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, a0);
      check("b2b_not_ready", {31'h0, bus.req_ready}, 32'h0);
      issue(2'b00, 16'h3001, 16'h0000, 16'h0000, 16'hCAFE, 1'b0, a1);
      issue(2'b00, 16'h4010, 16'h0000, 16'h0000, 16'h1234, 1'b0, a2);
      check("b2b_space1", a1 - a0, 32'd4);
      check("b2b_space2", a2 - a1, 32'd4);
      drain();

      // Reset pulsed during WAIT1 of an LDI: only the pointer read may happen.
      issue(2'b10, 16'h3002, 16'h0000, 16'h5000, 16'h00A5, 1'b1, a0);
      bus.req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("abort_en", {31'h0, bus.dmem_en}, 32'h0);
      check("abort_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
      check("abort_addr", {16'h0, bus.dmem_addr}, 32'h0);
      check("abort_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
      repeat (8) @(negedge clock);
      check("abort_quiet", {16'h0, 8'(strb_q.size()), 8'(rsp_q.size())}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
